// File: rtl/fsusb_tx_serializer.sv
// rtl/fsusb_tx_serializer.sv - Full-speed USB line transmitter: SYNC, NRZI, bit stuffing, EOP
//
// Ports:
//   c        48 MHz clock
//   rst_n    asynchronous active-low reset
//   d        packet byte, held with dv until rdy
//   dv       byte valid; high in IDLE starts a packet
//   d_last   marks d as the final byte of the packet
//   rdy      one-cycle pulse when d/d_last are captured
//   vp, vm   D+ / D- drive levels (J=10, K=01, SE0=00)
//   oe_n     active-low PHY output enable
//   busy     high from packet start through the end of EOP
//   underrun one-cycle pulse when a packet is aborted for lack of data

module fsusb_tx_serializer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       c,
    input  logic       rst_n,
    input  logic [7:0] d,
    input  logic       dv,
    input  logic       d_last,
    output logic       rdy,
    output logic       vp,
    output logic       vm,
    output logic       oe_n,
    output logic       busy,
    output logic       underrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_WRAP = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_ABORT,
        ST_EOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic          lvl_q, lvl_d;             // differential level, 1 = J
    logic          se0_q, se0_d;
    logic          oe_n_q, oe_n_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    sh_q, sh_d;               // remaining data bits, LSB next
    logic [2:0]    bits_left_q, bits_left_d; // data bits of current byte still to send
    logic          last_q, last_d;
    logic [2:0]    stuff_q, stuff_d;         // consecutive transmitted ones
    logic [3:0]    seq_q, seq_d;             // bit index within SYNC / ABORT / EOP

    logic wrap;
    logic send;
    logic send_bit;
    logic boundary;
    logic goto_eop;

    assign wrap = (clk_cnt_q == CLK_WRAP);

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            lvl_q       <= 1'b1;
            se0_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
            underrun_q  <= 1'b0;
            sh_q        <= '0;
            bits_left_q <= '0;
            last_q      <= 1'b0;
            stuff_q     <= '0;
            seq_q       <= '0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            lvl_q       <= lvl_d;
            se0_q       <= se0_d;
            oe_n_q      <= oe_n_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
            underrun_q  <= underrun_d;
            sh_q        <= sh_d;
            bits_left_q <= bits_left_d;
            last_q      <= last_d;
            stuff_q     <= stuff_d;
            seq_q       <= seq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        lvl_d       = lvl_q;
        se0_d       = se0_q;
        oe_n_d      = oe_n_q;
        busy_d      = busy_q;
        rdy_d       = 1'b0;
        underrun_d  = 1'b0;
        sh_d        = sh_q;
        bits_left_d = bits_left_q;
        last_d      = last_q;
        stuff_d     = stuff_q;
        seq_d       = seq_q;
        send        = 1'b0;
        send_bit    = 1'b0;
        boundary    = 1'b0;
        goto_eop    = 1'b0;

        if (state_q != ST_IDLE) begin
            clk_cnt_d = wrap ? '0 : clk_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (dv) begin
                    // First SYNC bit is a 0: J -> K on the very next cycle.
                    state_d   = ST_SYNC;
                    oe_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    lvl_d     = 1'b0;
                    se0_d     = 1'b0;
                    seq_d     = 4'd1;
                    stuff_d   = '0;
                    last_d    = 1'b0;
                    clk_cnt_d = '0;
                end
            end

            ST_SYNC: begin
                if (wrap) begin
                    if (seq_q == 4'd8) begin
                        boundary = 1'b1;
                    end else begin
                        // 0x80 LSB first: seven zeros then a one.
                        send     = 1'b1;
                        send_bit = (seq_q == 4'd7);
                        seq_d    = seq_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (wrap) begin
                    // A pending stuff bit goes out before anything else,
                    // including the next byte or EOP.
                    if (stuff_q == 3'd6) begin
                        lvl_d   = ~lvl_q;
                        stuff_d = '0;
                    end else if (bits_left_q != 3'd0) begin
                        send        = 1'b1;
                        send_bit    = sh_q[0];
                        sh_d        = {1'b0, sh_q[7:1]};
                        bits_left_d = bits_left_q - 3'd1;
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end

            ST_ABORT: begin
                // Line level is held; no stuffing, so the receiver sees a
                // bit-stuff violation and drops the packet.
                if (wrap) begin
                    if (seq_q == 4'd7) begin
                        goto_eop = 1'b1;
                    end else begin
                        seq_d = seq_q + 4'd1;
                    end
                end
            end

            ST_EOP: begin
                if (wrap) begin
                    case (seq_q)
                        4'd1: seq_d = 4'd2;
                        4'd2: begin
                            se0_d = 1'b0;
                            lvl_d = 1'b1;
                            seq_d = 4'd3;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            oe_n_d  = 1'b1;
                            busy_d  = 1'b0;
                            lvl_d   = 1'b1;
                        end
                    endcase
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Byte boundary: previous byte (or SYNC) and its stuff bit are done.
        if (boundary) begin
            if (last_q) begin
                goto_eop = 1'b1;
            end else if (dv) begin
                state_d     = ST_DATA;
                sh_d        = {1'b0, d[7:1]};
                last_d      = d_last;
                bits_left_d = 3'd7;
                rdy_d       = 1'b1;
                send        = 1'b1;
                send_bit    = d[0];
            end else begin
                state_d    = ST_ABORT;
                underrun_d = 1'b1;
                seq_d      = 4'd1;
            end
        end

        if (goto_eop) begin
            state_d = ST_EOP;
            se0_d   = 1'b1;
            seq_d   = 4'd1;
        end

        // NRZI: a 0 toggles the line, a 1 holds it and counts toward stuffing.
        if (send) begin
            if (!send_bit) begin
                lvl_d   = ~lvl_q;
                stuff_d = '0;
            end else begin
                stuff_d = stuff_q + 3'd1;
            end
        end
    end

    assign vp       = lvl_q & ~se0_q;
    assign vm       = ~lvl_q & ~se0_q;
    assign oe_n     = oe_n_q;
    assign busy     = busy_q;
    assign rdy      = rdy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_fsusb_tx_serializer.sv
// tb/tb_fsusb_tx_serializer.sv - Self-checking bench for fsusb_tx_serializer

module tb_fsusb_tx_serializer;

    localparam int CPB = 4;

    logic       c = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d = 8'h00;
    logic       dv = 1'b0;
    logic       d_last = 1'b0;
    logic       rdy, vp, vm, oe_n, busy, underrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 c = ~c;

    fsusb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .c        (c),
        .rst_n    (rst_n),
        .d        (d),
        .dv       (dv),
        .d_last   (d_last),
        .rdy      (rdy),
        .vp       (vp),
        .vm       (vm),
        .oe_n     (oe_n),
        .busy     (busy),
        .underrun (underrun)
    );

    typedef struct {
        string      name;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       l0;
        logic       l1;
        string      line;      // one char per bit time: J, K, 0 = SE0
        int         oe_cycles;
        int         rdy0;      // cycle index of rdy pulses, -1 = none
        int         rdy1;
        int         und_at;    // cycle index of underrun, -1 = none
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    function automatic byte sym();
        if (vp && !vm)       return "J";
        else if (!vp && vm)  return "K";
        else if (!vp && !vm) return "0";
        else                 return "X";
    endfunction

    // Caller must be #1 after a rising edge. Returns #1 after a rising edge.
    task automatic run_packet(input vec_t v);
        byte   line_q[$];
        string act;
        int    oe_cnt = 0, rdy_cnt = 0, und_cnt = 0, und_pos = -1;
        int    rdy_pos0 = -1, rdy_pos1 = -1;
        int    sent = 0, overlap = 0, bad_hold = 0, busy_bad = 0;
        int    busy_after = -1;
        bit    seen_oe = 0, done = 0;

        d = v.b0; d_last = v.l0; dv = 1'b1;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(posedge c); #1;
            if (!oe_n) begin
                oe_cnt++;
                seen_oe = 1;
                line_q.push_back(sym());
                if (!busy) busy_bad++;
            end else if (seen_oe) begin
                done = 1;
                busy_after = int'(busy);
            end
            if (rdy && underrun) overlap++;
            if (underrun) begin
                und_cnt++;
                und_pos = cyc;
            end
            if (rdy) begin
                if (rdy_cnt == 0) rdy_pos0 = cyc;
                else if (rdy_cnt == 1) rdy_pos1 = cyc;
                rdy_cnt++;
                sent++;
                if (sent < v.nbytes) begin
                    d = v.b1; d_last = v.l1;
                end else begin
                    dv = 1'b0; d = 8'h00; d_last = 1'b0;
                end
            end
        end
        dv = 1'b0;

        act = "";
        for (int i = 0; i < line_q.size(); i += CPB) begin
            act = $sformatf("%s%c", act, line_q[i]);
            for (int k = 1; k < CPB; k++)
                if (i + k < line_q.size() && line_q[i+k] != line_q[i]) bad_hold++;
        end

        check({v.name, " finished"}, int'(done), 1);
        check_str({v.name, " line"}, act, v.line);
        check({v.name, " oe_n low cycles"}, oe_cnt, v.oe_cycles);
        check({v.name, " bit hold"}, bad_hold, 0);
        check({v.name, " busy during packet"}, busy_bad, 0);
        check({v.name, " busy after"}, busy_after, 0);
        check({v.name, " rdy count"}, rdy_cnt, v.nbytes);
        check({v.name, " rdy0 cycle"}, rdy_pos0, v.rdy0);
        check({v.name, " rdy1 cycle"}, rdy_pos1, v.rdy1);
        check({v.name, " underrun count"}, und_cnt, (v.und_at >= 0) ? 1 : 0);
        check({v.name, " underrun cycle"}, und_pos, v.und_at);
        check({v.name, " rdy/underrun overlap"}, overlap, 0);
    endtask

    initial begin
        int oe_low;

        vecs[0] = '{"single_00", 1, 8'h00, 8'h00, 1'b1, 1'b0,
                    "KJKJKJKKJKJKJKJK00J", 76, 32, -1, -1};
        vecs[1] = '{"single_ff", 1, 8'hFF, 8'h00, 1'b1, 1'b0,
                    "KJKJKJKKKKKKKJJJJ00J", 80, 32, -1, -1};
        vecs[2] = '{"b2b_c3_3c", 2, 8'hC3, 8'h3C, 1'b0, 1'b1,
                    "KJKJKJKKKKJKJKKKJKKKKKJK00J", 108, 32, 64, -1};
        vecs[3] = '{"xstuff_f0_3f", 2, 8'hF0, 8'h3F, 1'b0, 1'b1,
                    "KJKJKJKKJKJKKKKKKKJJJJJKJ00J", 112, 32, 64, -1};
        vecs[4] = '{"underrun_01", 1, 8'h01, 8'h00, 1'b0, 1'b0,
                    "KJKJKJKKKJKJKJKJJJJJJJJ00J", 104, 32, -1, 64};
        vecs[5] = '{"stuff_before_eop", 2, 8'h00, 8'hFC, 1'b0, 1'b1,
                    "KJKJKJKKJKJKJKJKJKKKKKKKJ00J", 112, 32, 64, -1};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge c);
        #1;
        check("reset oe_n", int'(oe_n), 1);
        check("reset vp", int'(vp), 1);
        check("reset vm", int'(vm), 0);
        check("reset busy", int'(busy), 0);
        check("reset rdy", int'(rdy), 0);
        check("reset underrun", int'(underrun), 0);
        @(posedge c); #1;
        rst_n = 1'b1;
        @(posedge c); #1;

        for (int i = 0; i < 6; i++) begin
            run_packet(vecs[i]);
            repeat (3) begin
                @(posedge c); #1;
            end
        end

        // Reset during the 3rd data bit (cycles 40..43 of the packet)
        d = 8'h00; d_last = 1'b1; dv = 1'b1;
        for (int k = 0; k <= 41; k++) begin
            @(posedge c); #1;
            if (rdy) dv = 1'b0;
        end
        check("pre-reset oe_n", int'(oe_n), 0);
        rst_n = 1'b0;
        #1;
        check("mid-reset oe_n", int'(oe_n), 1);
        check("mid-reset vp", int'(vp), 1);
        check("mid-reset vm", int'(vm), 0);
        check("mid-reset busy", int'(busy), 0);
        @(posedge c); #1;
        rst_n = 1'b1;
        dv = 1'b0;
        oe_low = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge c); #1;
            if (!oe_n || busy) oe_low++;
        end
        check("idle after reset", oe_low, 0);
        run_packet(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
